wb_bus_arbiter: RTL and testbench

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

---
 rtl/wb_bus_arbiter_if.sv | 31 +++
 rtl/wb_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bus_arbiter_if.sv
// Shared-bus arbitration signals: per-master requests, slave ACK, registered grants.
// The arbiter uses the slave modport; the request side uses the master modport.
interface wb_bus_arbiter_if #(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned ID_WIDTH  = 2
);
  logic [N_MASTERS-1:0] cyc_i;
  logic                 ACK_I;
  logic [N_MASTERS-1:0] gnt_wb_o;
  logic [ID_WIDTH-1:0]  gnt_id_o;
  logic                 bus_busy_o;
  logic                 timeout_o;

  modport slave (
    input  cyc_i,
    input  ACK_I,
    output gnt_wb_o,
    output gnt_id_o,
    output bus_busy_o,
    output timeout_o
  );

  modport master (
    output cyc_i,
    output ACK_I,
    input  gnt_wb_o,
    input  gnt_id_o,
    input  bus_busy_o,
    input  timeout_o
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with non-preemptive grants, one dead cycle between
// owners and an ACK watchdog that revokes and masks a stalled master.
module wb_bus_arbiter #(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ID_WIDTH       = 2
) (
  input logic              clk,
  input logic              rst,
  wb_bus_arbiter_if.slave  bus
);

  localparam int unsigned WdW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLimit = WdW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [WdW-1:0] WdMax   = '1;
  localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(N_MASTERS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StRelease
  } state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] gnt_q, gnt_d;
  logic [N_MASTERS-1:0] mask_q, mask_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [ID_WIDTH-1:0]  last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic [WdW-1:0]       wdog_q, wdog_d;
  // Low for the first edge after reset release so the earliest grant lands on the second.
  logic                 armed_q;

  logic [N_MASTERS-1:0] eligible;
  logic                 found;
  logic [ID_WIDTH-1:0]  winner;
  logic [ID_WIDTH-1:0]  cand;

  // Round-robin search from last_q+1, wrapping at N_MASTERS-1.
  always_comb begin
    eligible = bus.cyc_i & ~mask_q;
    found    = 1'b0;
    winner   = last_q;
    cand     = last_q;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (cand == LastId) begin
        cand = '0;
      end else begin
        cand = cand + 1'b1;
      end
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    last_d    = last_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    wdog_d    = wdog_q;
    // A master leaves the masked set as soon as its request is seen low.
    mask_d    = mask_q & bus.cyc_i;

    unique case (state_q)
      // The dead cycle ends with the same arbitration IDLE would perform, so
      // back-to-back owners are separated by exactly one idle bus cycle.
      StIdle, StRelease: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (armed_q && found) begin
          state_d        = StGrant;
          gnt_d          = '0;
          gnt_d[winner]  = 1'b1;
          id_d           = winner;
          last_d         = winner;
          busy_d         = 1'b1;
          wdog_d         = '0;
        end
      end

      StGrant: begin
        if (!bus.cyc_i[id_q]) begin
          // Normal release takes priority over a coincident watchdog expiry.
          state_d = StRelease;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if ((TIMEOUT_CYCLES != 0) && (wdog_q == WdLimit) && !bus.ACK_I) begin
          state_d      = StRelease;
          gnt_d        = '0;
          busy_d       = 1'b0;
          timeout_d    = 1'b1;
          mask_d[id_q] = 1'b1;
        end else if (bus.ACK_I) begin
          wdog_d = '0;
        end else if (wdog_q != WdMax) begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      last_q    <= LastId;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
      armed_q   <= 1'b1;
    end
  end

  assign bus.gnt_wb_o   = gnt_q;
  assign bus.gnt_id_o   = id_q;
  assign bus.bus_busy_o = busy_q;
  assign bus.timeout_o  = timeout_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: fixed vector table, directed corner sequences and a
// randomized run against an ownership-level reference model.
module tb_wb_bus_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  wb_bus_arbiter_if #(.N_MASTERS(4), .ID_WIDTH(2)) bus ();

  wb_bus_arbiter #(
    .N_MASTERS     (4),
    .TIMEOUT_CYCLES(TO),
    .ID_WIDTH      (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the bus, who was served last, who is banned.
  int       m_owner;
  int       m_last;
  int       m_id;
  int       m_silent;
  bit       m_ready;
  bit       m_tmo;
  bit [3:0] m_mask;

  function automatic void model_reset();
    m_owner  = -1;
    m_last   = 3;
    m_id     = 0;
    m_silent = 0;
    m_ready  = 1'b0;
    m_tmo    = 1'b0;
    m_mask   = 4'b0000;
  endfunction

  function automatic void model_step(logic [3:0] c, logic a);
    bit [3:0] new_mask;
    new_mask = m_mask & c;
    m_tmo    = 1'b0;
    if (m_owner >= 0) begin
      if (!c[m_owner]) begin
        m_owner = -1;
      end else if (m_silent == TO - 1 && !a) begin
        new_mask[m_owner] = 1'b1;
        m_tmo             = 1'b1;
        m_owner           = -1;
      end else begin
        m_silent = a ? 0 : m_silent + 1;
      end
    end else if (m_ready) begin
      for (int d = 1; d <= 4; d++) begin
        int k;
        k = (m_last + d) % 4;
        if (c[k] && !m_mask[k]) begin
          m_owner  = k;
          m_last   = k;
          m_id     = k;
          m_silent = 0;
          break;
        end
      end
    end
    m_mask  = new_mask;
    m_ready = 1'b1;
  endfunction

  task automatic chk(input string name, input logic [3:0] g, input logic [1:0] id,
                     input logic b, input logic t);
    n_total++;
    if ({bus.gnt_wb_o, bus.gnt_id_o, bus.bus_busy_o, bus.timeout_o} === {g, id, b, t}) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=%0d busy=%b tmo=%b",
               name, $time, bus.gnt_wb_o, bus.gnt_id_o, bus.bus_busy_o, bus.timeout_o,
               g, id, b, t);
    end
  endtask

  task automatic model_chk(input string name);
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk(name, g, 2'(m_id), m_owner >= 0, m_tmo);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs sampled at negedge.
  task automatic tick();
    @(posedge clk);
    model_step(bus.cyc_i, bus.ACK_I);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs clear without a clock, releases at a negedge.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs[19];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, want finish before 1 ms");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rst        = 1'b0;
    bus.cyc_i  = 4'b0000;
    bus.ACK_I  = 1'b0;
    model_reset();

    // All four requesting with a one-cycle drop after each grant, then mid-grant requests.
    vecs[0]  = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[2]  = '{4'b1110, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[3]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[5]  = '{4'b1101, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{4'b1011, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[9]  = '{4'b0111, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[10] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[12] = '{4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[14] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[15] = '{4'b1000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[16] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    foreach (vecs[i]) begin
      bus.cyc_i = vecs[i].cyc;
      bus.ACK_I = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].tmo);
    end

    // Lone master with periodic ACK keeps the grant and never times out.
    do_reset();
    bus.cyc_i = 4'b0100;
    tick();
    chk("ack_arm", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("ack_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      bus.ACK_I = (i % 5 == 4);
      tick();
      chk($sformatf("ack_hold%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    bus.ACK_I = 1'b0;
    bus.cyc_i = 4'b0000;
    tick();
    chk("ack_release", 4'b0000, 2'd2, 1'b0, 1'b0);

    // Watchdog revokes master 1 after eight silent grant cycles and bans it.
    do_reset();
    bus.cyc_i = 4'b0010;
    tick();
    chk("to_arm", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int t = 2; t <= 9; t++) begin
      if (t == 9) bus.cyc_i = 4'b1010;
      tick();
      chk($sformatf("to_hold%0d", t), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk("to_revoke", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk("to_m3_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.cyc_i = 4'b0010;
    tick();
    chk("to_m3_release", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    chk("to_masked_a", 4'b0000, 2'd3, 1'b0, 1'b0);
    tick();
    chk("to_masked_b", 4'b0000, 2'd3, 1'b0, 1'b0);
    bus.cyc_i = 4'b0000;
    tick();
    chk("to_drop", 4'b0000, 2'd3, 1'b0, 1'b0);
    bus.cyc_i = 4'b0010;
    tick();
    chk("to_unmasked", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.cyc_i = 4'b0000;
    tick();

    // Drop on the watchdog limit cycle is a normal release.
    do_reset();
    bus.cyc_i = 4'b0001;
    tick();
    for (int t = 2; t <= 9; t++) begin
      tick();
      chk($sformatf("lim_hold%0d", t), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    bus.cyc_i = 4'b0000;
    tick();
    chk("lim_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.cyc_i = 4'b0001;
    tick();
    chk("lim_regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.cyc_i = 4'b0000;
    tick();

    // Reset while master 2 owns the bus, then regrant.
    do_reset();
    bus.cyc_i = 4'b0100;
    tick();
    tick();
    chk("rst_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
    do_reset();
    tick();
    chk("rst_post_arm", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    bus.cyc_i = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] c;
      c = bus.cyc_i;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 15) == 0) c[k] = ~c[k];
      end
      bus.cyc_i = c;
      bus.ACK_I = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
      tick();
      model_chk($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
